// File: rtl/qspi_axi_wr_dma.sv
// Write-DMA master: drains 32-bit words from the QSPI read stream into RAM
// as single-beat AXI4 writes at incrementing word-aligned addresses.
module qspi_axi_wr_dma #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned LEN_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] words_done,
    input  logic             s_valid,
    input  logic [31:0]      s_data,
    output logic             s_ready,
    output logic             awvalid,
    output logic [31:0]      awaddr,
    input  logic             awready,
    output logic             wvalid,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb,
    input  logic             wready,
    input  logic             bvalid,
    output logic             bready
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_RESP, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] words_done_q, words_done_d;
    logic [31:0]      tmo_q, tmo_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic             s_ready_q, s_ready_d;
    logic             awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic [31:0]      awaddr_q, awaddr_d, wdata_q, wdata_d;
    logic [3:0]       wstrb_q, wstrb_d;

    logic             start_ok, aw_ok, w_ok, b_fire, tmo_hit, last_word;
    logic [LEN_W-1:0] wd_inc;

    // A start landing in the cycle done is high must not relaunch the engine.
    assign start_ok  = start && !done_q;
    assign aw_ok     = !awvalid_q || awready;
    assign w_ok      = !wvalid_q || wready;
    assign b_fire    = bready_q && bvalid;
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && ((tmo_q + 32'd1) == TIMEOUT_CYCLES);
    assign wd_inc    = words_done_q + LEN_W'(1);
    assign last_word = (wd_inc == len_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            tmo_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            s_ready_q    <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            words_done_q <= words_done_d;
            tmo_q        <= tmo_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            s_ready_q    <= s_ready_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = (len_words == '0) ? S_DONE : S_FETCH;
            S_FETCH: if (s_valid) state_d = S_ISSUE;
            S_ISSUE: begin
                if (tmo_hit)            state_d = S_DONE;
                else if (aw_ok && w_ok) state_d = S_RESP;
            end
            S_RESP: begin
                if (b_fire)       state_d = last_word ? S_DONE : S_FETCH;
                else if (tmo_hit) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        addr_d       = addr_q;
        len_d        = len_q;
        words_done_d = words_done_q;
        tmo_d        = tmo_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        s_ready_d    = s_ready_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        case (state_q)
            S_IDLE: if (start_ok) begin
                addr_d       = {dst_addr[31:2], 2'b00};
                len_d        = len_words;
                words_done_d = '0;
                err_d        = 1'b0;
                busy_d       = 1'b1;
                s_ready_d    = (len_words != '0);
            end
            S_FETCH: if (s_valid) begin
                s_ready_d = 1'b0;
                wdata_d   = s_data;
                awaddr_d  = addr_q;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                wstrb_d   = 4'hF;
                tmo_d     = '0;
            end
            S_ISSUE: begin
                tmo_d = tmo_q + 32'd1;
                // Abort wins over a handshake landing on the timeout edge.
                if (tmo_hit) begin
                    err_d     = 1'b1;
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    wstrb_d   = '0;
                    bready_d  = 1'b0;
                end else begin
                    if (awvalid_q && awready) awvalid_d = 1'b0;
                    if (wvalid_q && wready) begin
                        wvalid_d = 1'b0;
                        wstrb_d  = '0;
                    end
                    if (aw_ok && w_ok) bready_d = 1'b1;
                end
            end
            S_RESP: begin
                tmo_d = tmo_q + 32'd1;
                if (b_fire) begin
                    bready_d     = 1'b0;
                    words_done_d = wd_inc;
                    addr_d       = addr_q + 32'd4;
                    s_ready_d    = !last_word;
                end else if (tmo_hit) begin
                    err_d    = 1'b1;
                    bready_d = 1'b0;
                end
            end
            S_DONE: begin
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign words_done = words_done_q;
    assign s_ready    = s_ready_q;
    assign awvalid    = awvalid_q;
    assign awaddr     = awaddr_q;
    assign wvalid     = wvalid_q;
    assign wdata      = wdata_q;
    assign wstrb      = wstrb_q;
    assign bready     = bready_q;

endmodule

// File: tb/tb_qspi_axi_wr_dma.sv
// Bench for qspi_axi_wr_dma: table of transfers against an AXI slave model,
// with a scoreboard of expected AW addresses and W data.
module tb_qspi_axi_wr_dma;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] dst_addr;
    logic [15:0] len_words;
    logic        busy, done, err;
    logic [15:0] words_done;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [3:0]  wstrb;

    qspi_axi_wr_dma #(.TIMEOUT_CYCLES(8), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .dst_addr(dst_addr), .len_words(len_words),
        .busy(busy), .done(done), .err(err), .words_done(words_done),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int unsigned len;
        int unsigned aw_lat;
        int unsigned w_lat;
        bit          b_en;
        int unsigned exp_wd;
        bit          exp_err;
        int unsigned exp_cyc;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] src_q[$];
    logic [31:0] exp_aw_q[$];
    logic [31:0] exp_w_q[$];
    logic [31:0] exp_addr;
    int unsigned aw_lat, w_lat, aw_cnt, w_cnt, b_count, done_count;
    bit          b_en, poke, saw_sready, saw_traffic;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One cycle: sample outputs at negedge, play upstream source + AXI slave.
    task automatic step(input bit st);
        @(negedge clk);
        start = st || (poke && done);
        if (poke && done) len_words = 16'd7;
        s_valid = (src_q.size() != 0);
        s_data  = s_valid ? src_q[0] : '0;
        awready = awvalid && (aw_cnt >= aw_lat);
        wready  = wvalid && (w_cnt >= w_lat);
        bvalid  = b_en && bready;
        if (s_ready) saw_sready = 1'b1;
        if (awvalid || wvalid) saw_traffic = 1'b1;
        if (s_valid && s_ready) begin
            exp_aw_q.push_back(exp_addr);
            exp_w_q.push_back(src_q[0]);
            exp_addr += 32'd4;
            void'(src_q.pop_front());
        end
        check("wstrb", {28'b0, wstrb}, wvalid ? 32'hF : 32'h0);
        if (awvalid) begin
            if (awready) begin
                check("aw_beat_expected", 32'(exp_aw_q.size() > 0), 32'd1);
                if (exp_aw_q.size() > 0) check("awaddr", awaddr, exp_aw_q.pop_front());
                aw_cnt = 0;
            end else aw_cnt++;
        end
        if (wvalid) begin
            if (wready) begin
                check("w_beat_expected", 32'(exp_w_q.size() > 0), 32'd1);
                if (exp_w_q.size() > 0) check("wdata", wdata, exp_w_q.pop_front());
                w_cnt = 0;
            end else w_cnt++;
        end
        if (bready) check("bready_after_aw_w", {30'b0, awvalid, wvalid}, 32'd0);
        if (bvalid && bready) b_count++;
        if (done) done_count++;
    endtask

    task automatic run_vec(input vec_t v, input int unsigned idx);
        int unsigned n;
        dst_addr  = v.addr;
        len_words = 16'(v.len);
        aw_lat = v.aw_lat; w_lat = v.w_lat; b_en = v.b_en;
        aw_cnt = 0; w_cnt = 0; b_count = 0; done_count = 0;
        saw_sready = 1'b0; saw_traffic = 1'b0; poke = 1'b0;
        exp_addr = {v.addr[31:2], 2'b00};
        for (int unsigned i = 0; i < v.len; i++) src_q.push_back((32'h11 * (i + 1)) + (idx << 24));
        step(1'b1);
        step(1'b0);
        check("busy_after_start", busy, 1);
        check("err_cleared_on_start", err, 0);
        check("words_done_cleared", words_done, 0);
        n = 1;
        poke = 1'b1;
        while (!done && n < 300) begin
            step(1'b0);
            n++;
        end
        check("done_seen", done, 1);
        if (v.exp_cyc != 0) check("cycles_to_done", n, v.exp_cyc);
        check("busy_at_done", busy, 0);
        check("words_done", words_done, v.exp_wd);
        check("err", err, v.exp_err);
        check("valids_idle_at_done", {29'b0, awvalid, wvalid, bready}, 0);
        check("b_handshakes", b_count, v.exp_wd);
        poke = 1'b0;
        step(1'b0);
        check("start_in_done_ignored", busy, 0);
        check("done_single_pulse", done, 0);
        check("s_ready_idle", s_ready, 0);
        step(1'b0);
        check("done_count", done_count, 1);
        check("aw_queue_drained", exp_aw_q.size(), 0);
        check("w_queue_drained", exp_w_q.size(), 0);
        if (v.len == 0) check("len0_no_traffic", {30'b0, saw_sready, saw_traffic}, 0);
        src_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        vecs[0] = '{32'h0000_1003, 4, 0, 0, 1'b1, 4, 1'b0, 14};
        vecs[1] = '{32'h0000_5000, 0, 0, 0, 1'b1, 0, 1'b0, 2};
        vecs[2] = '{32'h0000_2000, 2, 3, 0, 1'b1, 2, 1'b0, 0};
        vecs[3] = '{32'h0000_3000, 2, 0, 3, 1'b1, 2, 1'b0, 0};
        vecs[4] = '{32'h0000_6000, 2, 0, 0, 1'b0, 0, 1'b1, 11};
        vecs[5] = '{32'hFFFF_FFFC, 2, 0, 0, 1'b1, 2, 1'b0, 8};
        vecs[6] = '{32'h0000_7000, 3, 2, 2, 1'b1, 3, 1'b0, 0};

        rst = 1'b1; start = 1'b0; dst_addr = '0; len_words = '0;
        s_valid = 1'b0; s_data = '0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        aw_lat = 0; w_lat = 0; b_en = 1'b0; poke = 1'b0;
        repeat (3) step(1'b0);
        check("reset_flags", {24'b0, busy, done, err, s_ready, awvalid, wvalid, bready, 1'b0}, 0);
        check("reset_wstrb", {28'b0, wstrb}, 0);
        check("reset_awaddr", awaddr, 0);
        check("reset_wdata", wdata, 0);
        check("reset_words_done", words_done, 0);
        rst = 1'b0;
        step(1'b0);

        for (int unsigned r = 0; r < 7; r++) run_vec(vecs[r], r);

        // Reset while an AW beat is outstanding, then a clean transfer.
        dst_addr = 32'h0000_4000; len_words = 16'd4;
        aw_lat = 5; w_lat = 0; b_en = 1'b1; aw_cnt = 0; w_cnt = 0;
        exp_addr = 32'h0000_4000;
        for (int unsigned i = 0; i < 4; i++) src_q.push_back(32'hA0 + i);
        step(1'b1);
        n = 0;
        while (!awvalid && n < 20) begin
            step(1'b0);
            n++;
        end
        check("awvalid_before_reset", awvalid, 1);
        rst = 1'b1;
        step(1'b0);
        check("midreset_flags", {24'b0, busy, done, err, s_ready, awvalid, wvalid, bready, 1'b0}, 0);
        check("midreset_wstrb", {28'b0, wstrb}, 0);
        check("midreset_awaddr", awaddr, 0);
        check("midreset_wdata", wdata, 0);
        check("midreset_words_done", words_done, 0);
        rst = 1'b0;
        src_q.delete(); exp_aw_q.delete(); exp_w_q.delete();
        step(1'b0);
        run_vec(vecs[0], 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/qspi_axi_wr_dma.md
Name: qspi_axi_wr_dma

Overview:
- Write-DMA master that drains 32-bit words from the QSPI read-data stream into system RAM over the AXI4 write channels (AW/W/B).
- Sits directly upstream of the AXI4 RAM slave, driving its awvalid/awaddr, wvalid/wdata/wstrb and bready inputs.
- Issues one single-beat write per word, with an incrementing word-aligned address.
- Reports completion, progress and response timeouts to the controller's register block.

Parameters:
- TIMEOUT_CYCLES, 1024: maximum cycles per word spent in ISSUE+RESP before abort; 0 disables the timeout.
- LEN_W, 16: width of the transfer-length and progress counters.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a transfer; sampled only in IDLE
- dst_addr  in  32  destination byte address, captured on start; bits [1:0] forced to 0
- len_words  in  LEN_W  number of 32-bit words to transfer, captured on start
- busy  out  1  high from the cycle after an accepted start until DONE completes
- done  out  1  one-cycle pulse at the end of a transfer (normal or aborted)
- err  out  1  sticky timeout flag; cleared by the next accepted start
- words_done  out  LEN_W  count of words with a completed B handshake
- s_valid  in  1  upstream word available
- s_data  in  32  upstream word
- s_ready  out  1  word accepted when s_valid && s_ready
- awvalid  out  1  AXI write-address valid
- awaddr  out  32  AXI write address
- awready  in  1  AXI write-address ready
- wvalid  out  1  AXI write-data valid
- wdata  out  32  AXI write data
- wstrb  out  4  AXI byte strobes; always 4'hF when wvalid
- bvalid  in  1  AXI write-response valid
- bready  out  1  AXI write-response ready

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - State goes to IDLE.
  - All outputs 0: busy, done, err, words_done, s_ready, awvalid, awaddr, wvalid, wdata, wstrb, bready.
  - Reset mid-transfer abandons any outstanding AXI beat; valids drop in the same edge.
- All outputs are registered.
- FSM states: IDLE, FETCH, ISSUE, RESP, DONE.
- IDLE:
  - On start: capture the address register <= {dst_addr[31:2],2'b0}, length <= len_words, clear words_done and err, set busy.
  - Next state is DONE if len_words==0 (no AXI traffic), else FETCH.
  - start while not in IDLE is ignored.
- FETCH:
  - s_ready=1.
  - On s_valid: latch s_data into wdata; set awvalid=1, wvalid=1, wstrb=4'hF, awaddr=address register; clear the timeout counter; go to ISSUE. s_ready drops the same edge.
- ISSUE:
  - awvalid and wvalid are held until their own handshake and dropped independently, in the cycle after their respective handshake edge.
  - awaddr and wdata stay stable while their valid is high.
  - AW and W may complete in the same cycle or in either order.
  - When both have completed: set bready=1, go to RESP.
- RESP:
  - On bvalid && bready: bready<=0, words_done+1, address register +4 (wraps modulo 2^32).
  - Next state is DONE if words_done+1 == length, else FETCH.
- DONE:
  - done=1 for exactly one cycle, busy<=0, return to IDLE.
  - A start in the cycle done is high is ignored.
- Minimum per-word latency is 3 cycles (FETCH, ISSUE, RESP), given zero-wait upstream and slave.
- Timeout:
  - The counter increments every cycle in ISSUE or RESP.
  - If it reaches TIMEOUT_CYCLES before the B handshake: err<=1; awvalid, wvalid and bready <= 0; go to DONE. words_done holds the completed count.
- bvalid outside RESP is ignored (bready=0).
- wstrb returns to 0 when wvalid drops.

Test Plan:
- start, dst_addr=0x0000_1003, len=4, slave always ready, words 0x11,0x22,0x33,0x44 -> AW addresses 0x1000,0x1004,0x1008,0x100C; wdata in order with wstrb=F; words_done=4; one done pulse; err=0; 3 cycles per word.
- len=0 -> no awvalid/wvalid/s_ready; done pulses 2 cycles after start; busy high for 1 cycle.
- awready delayed 3 cycles while wready is immediate, then the reverse -> each valid held until its own handshake, no duplicate beats, bready only after both complete.
- bvalid never asserted, TIMEOUT_CYCLES=8, len=2 -> after 8 cycles in ISSUE/RESP: err=1, all valids 0, done pulse, words_done=0; next start clears err.
- dst_addr=0xFFFF_FFFC, len=2 -> awaddr 0xFFFF_FFFC then 0x0000_0000.
- rst asserted while awvalid=1 mid-transfer -> next cycle all outputs 0, state IDLE; a fresh start then completes normally.
